// File: rtl/ram_dump_reader.sv
// ram_dump_reader: reads a block of consecutive RAM words and streams them out over valid/ready.
// Latency: one RD cycle + READ_LATENCY-1 wait cycles + one OUT cycle per word (ready held high).
// Backpressure: a word is held stable in OUT until accepted; no new RAM read is issued while it is held.
// Optional feature: define DUMP_CHECKSUM_EN to build the XOR checksum accumulator (else checksum = 0).

module ram_dump_reader #(
   parameter int ADDR_W       = 64,
   parameter int DATA_W       = 64,
   parameter int CNT_W        = 16,
   parameter int ADDR_STEP    = 1,
   parameter int READ_LATENCY = 1
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_start_addr,
   input  logic [CNT_W-1:0]  i_word_count,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_ram_cs,
   output logic              o_ram_we,
   output logic              o_ram_oe,
   output logic [ADDR_W-1:0] o_ram_addr,
   input  logic [DATA_W-1:0] i_ram_rdata,
   output logic              o_dump_valid,
   input  logic              i_dump_ready,
   output logic [ADDR_W-1:0] o_dump_addr,
   output logic [DATA_W-1:0] o_dump_data,
   output logic [DATA_W-1:0] o_checksum
);

   // S_ZERO gives an empty block the same two-cycle busy window as the start-to-done path expects
   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_WT   = 3'd2,
      S_OUT  = 3'd3,
      S_FIN  = 3'd4,
      S_ZERO = 3'd5
   } state_t;

   localparam logic              LAT1    = (READ_LATENCY == 1);
   localparam logic [2:0]        WT_LOAD = (READ_LATENCY > 1) ? 3'(READ_LATENCY - 2) : 3'd0;
   localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

   state_t            r_state;
   state_t            w_next;
   logic [ADDR_W-1:0] r_addr;
   logic [CNT_W-1:0]  r_rem;
   logic [2:0]        r_wait;
   logic [ADDR_W-1:0] r_dump_addr;
   logic [DATA_W-1:0] r_dump_data;
   logic              w_start_ok;
   logic              w_capture;
   logic              w_accept;

   // State register; reset aborts any block in flight without a done pulse
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and strobe decode
   always_comb begin
      w_next     = r_state;
      w_start_ok = 1'b0;
      w_capture  = 1'b0;
      w_accept   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_start_ok = 1'b1;
               w_next     = (i_word_count == '0) ? S_ZERO : S_RD;
            end
         end
         S_ZERO: w_next = S_FIN;
         S_RD: begin
            if (LAT1) begin
               w_capture = 1'b1;
               w_next    = S_OUT;
            end else begin
               w_next = S_WT;
            end
         end
         S_WT: begin
            if (r_wait == 3'd0) begin
               w_capture = 1'b1;
               w_next    = S_OUT;
            end
         end
         S_OUT: begin
            if (i_dump_ready) begin
               w_accept = 1'b1;
               w_next   = (r_rem == CNT_W'(1)) ? S_FIN : S_RD;
            end
         end
         S_FIN:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Address/count tracking, read-latency wait counter and dump word capture
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_addr      <= '0;
         r_rem       <= '0;
         r_wait      <= 3'd0;
         r_dump_addr <= '0;
         r_dump_data <= '0;
      end else begin
         if (w_start_ok) begin
            r_addr <= i_start_addr;
            r_rem  <= i_word_count;
         end
         if (r_state == S_RD) begin
            r_wait <= WT_LOAD;
         end else if (r_state == S_WT) begin
            r_wait <= r_wait - 3'd1;
         end
         if (w_capture) begin
            r_dump_data <= i_ram_rdata;
            r_dump_addr <= r_addr;
         end
         if (w_accept) begin
            r_addr <= r_addr + STEP;
            r_rem  <= r_rem - CNT_W'(1);
         end
      end
   end

`ifdef DUMP_CHECKSUM_EN
   logic [DATA_W-1:0] r_csum;

   // XOR of every accepted word; cleared on accepted start, held after done
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         r_csum <= '0;
      end else if (w_start_ok) begin
         r_csum <= '0;
      end else if (w_accept) begin
         r_csum <= r_csum ^ r_dump_data;
      end
   end

   assign o_checksum = r_csum;
`else
   assign o_checksum = '0;
`endif

   assign o_busy       = (r_state != S_IDLE);
   assign o_done       = (r_state == S_FIN);
   assign o_ram_cs     = (r_state == S_RD);
   assign o_ram_oe     = (r_state == S_RD);
   assign o_ram_we     = 1'b0;
   assign o_ram_addr   = r_addr;
   assign o_dump_valid = (r_state == S_OUT);
   assign o_dump_addr  = r_dump_addr;
   assign o_dump_data  = r_dump_data;

endmodule
